// File: rtl/debug_host_seq.sv
// rtl/debug_host_seq.sv - host-side debugger command sequencer over a UART FIFO interface
// Ports:
//   i_clk, i_reset                        clock, asynchronous active-low reset
//   i_pw_en, i_pw_addr, i_pw_data         program buffer write port (ignored while busy)
//   i_start, i_mode, i_prog_sz, i_steps   sequence request, sampled when start is accepted
//   i_tx_full, o_wr_uart, o_w_data        UART TX FIFO side
//   i_rx_empty, i_r_data, o_rd_uart       UART RX FIFO side (first-word-fall-through)
//   o_rx_valid, o_rx_data, o_rx_cnt       captured dump bytes and running total
//   o_busy, o_done, o_err, o_state        sequence status
module debug_host_seq #(
  parameter int         INST_SZ    = 32,
  parameter int         PROG_DEPTH = 16,
  parameter int         ADDR_W     = 4,
  parameter int         DUMP_BYTES = 66,
  parameter int         TIMEOUT    = 1000000,
  parameter logic [7:0] CMD_LOAD   = 8'hFE,
  parameter logic [7:0] CMD_RUN    = 8'hF0,
  parameter logic [7:0] CMD_STEP   = 8'hF1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pw_en,
  input  logic [ADDR_W-1:0]  i_pw_addr,
  input  logic [INST_SZ-1:0] i_pw_data,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [7:0]         i_prog_sz,
  input  logic [7:0]         i_steps,
  input  logic               i_tx_full,
  output logic               o_wr_uart,
  output logic [7:0]         o_w_data,
  input  logic               i_rx_empty,
  input  logic [7:0]         i_r_data,
  output logic               o_rd_uart,
  output logic               o_rx_valid,
  output logic [7:0]         o_rx_data,
  output logic [15:0]        o_rx_cnt,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [2:0]         o_state
);

  localparam int NBYTES = INST_SZ / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DUMP_W = $clog2(DUMP_BYTES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [7:0]        DEPTH8    = 8'(PROG_DEPTH);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
  localparam logic [DUMP_W-1:0] LAST_DUMP = DUMP_W'(DUMP_BYTES - 1);
  localparam logic [TMO_W-1:0]  LAST_IDLE = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_LOAD  = 3'd1,
    S_SIZE  = 3'd2,
    S_INST  = 3'd3,
    S_CMD   = 3'd4,
    COLLECT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              state;
  logic                mode_q;
  logic [7:0]          sz_q;
  logic [7:0]          steps_q;   // STEP commands still to issue, including the current one
  logic [7:0]          inst_idx;
  logic [BYTE_W-1:0]   byte_idx;
  logic [DUMP_W-1:0]   dump_cnt;
  logic [TMO_W-1:0]    idle_cnt;

  logic [INST_SZ-1:0]  prog_mem [PROG_DEPTH];
  logic [INST_SZ-1:0]  cur_inst;

  logic                sending;
  logic [7:0]          tx_byte;
  logic                tx_fire;
  logic                rx_fire;
  logic                bad_req;

  // Program buffer has no reset so a loaded program survives a sequence abort.
  always_ff @(posedge i_clk) begin
    if (i_pw_en && !o_busy && (32'(i_pw_addr) < PROG_DEPTH))
      prog_mem[i_pw_addr] <= i_pw_data;
  end

  assign cur_inst = prog_mem[inst_idx[ADDR_W-1:0]];

  always_comb begin
    sending = 1'b0;
    tx_byte = 8'h00;
    case (state)
      S_LOAD: begin sending = 1'b1; tx_byte = CMD_LOAD; end
      S_SIZE: begin sending = 1'b1; tx_byte = sz_q; end
      S_INST: begin sending = 1'b1; tx_byte = cur_inst[{byte_idx, 3'b000} +: 8]; end
      S_CMD:  begin sending = 1'b1; tx_byte = mode_q ? CMD_STEP : CMD_RUN; end
      default: ;
    endcase
  end

  // TX/RX strobes follow the FIFO flags combinationally so transfers run at one byte per cycle.
  assign tx_fire    = sending && !i_tx_full;
  assign rx_fire    = (state == COLLECT) && !i_rx_empty;
  assign o_wr_uart  = tx_fire;
  assign o_w_data   = tx_fire ? tx_byte : 8'h00;
  assign o_rd_uart  = rx_fire;
  assign o_rx_valid = rx_fire;
  assign o_rx_data  = rx_fire ? i_r_data : 8'h00;
  assign o_state    = state;

  assign bad_req = (i_prog_sz == 8'd0) || (i_prog_sz > DEPTH8) || (i_mode && (i_steps == 8'd0));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      sz_q     <= 8'd0;
      steps_q  <= 8'd0;
      inst_idx <= 8'd0;
      byte_idx <= '0;
      dump_cnt <= '0;
      idle_cnt <= '0;
      o_rx_cnt <= 16'd0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      if (rx_fire && (o_rx_cnt != 16'hFFFF))
        o_rx_cnt <= o_rx_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (i_start) begin
            if (bad_req) begin
              o_done <= 1'b0;
              o_err  <= 1'b1;
              state  <= DONE;
            end else begin
              mode_q   <= i_mode;
              sz_q     <= i_prog_sz;
              steps_q  <= i_steps;
              inst_idx <= 8'd0;
              byte_idx <= '0;
              o_rx_cnt <= 16'd0;
              o_done   <= 1'b0;
              o_err    <= 1'b0;
              o_busy   <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end

        S_LOAD: if (tx_fire) state <= S_SIZE;

        S_SIZE: if (tx_fire) state <= S_INST;

        S_INST: begin
          if (tx_fire) begin
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              if (inst_idx == sz_q - 8'd1)
                state <= S_CMD;
              else
                inst_idx <= inst_idx + 8'd1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end

        S_CMD: begin
          if (tx_fire) begin
            dump_cnt <= '0;
            idle_cnt <= '0;
            state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (rx_fire) begin
            idle_cnt <= '0;
            if (dump_cnt == LAST_DUMP) begin
              dump_cnt <= '0;
              if (!mode_q || (steps_q == 8'd1)) begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
                state  <= DONE;
              end else begin
                steps_q <= steps_q - 8'd1;
                state   <= S_CMD;
              end
            end else begin
              dump_cnt <= dump_cnt + 1'b1;
            end
          end else if (idle_cnt == LAST_IDLE) begin
            // TIMEOUT consecutive empty cycles without a dump byte
            o_busy <= 1'b0;
            o_err  <= 1'b1;
            state  <= DONE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host_seq.sv
// tb/tb_debug_host_seq.sv - randomized self-checking bench for debug_host_seq
module tb_debug_host_seq;

  localparam int NB    = 4;
  localparam int DEPTH = 16;
  localparam int DUMP  = 66;
  localparam int TMO   = 100;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_pw_en;
  logic [3:0]  i_pw_addr;
  logic [31:0] i_pw_data;
  logic        i_start;
  logic        i_mode;
  logic [7:0]  i_prog_sz;
  logic [7:0]  i_steps;
  logic        i_tx_full;
  logic        o_wr_uart;
  logic [7:0]  o_w_data;
  logic        i_rx_empty;
  logic [7:0]  i_r_data;
  logic        o_rd_uart;
  logic        o_rx_valid;
  logic [7:0]  o_rx_data;
  logic [15:0] o_rx_cnt;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [2:0]  o_state;

  always #5 i_clk = ~i_clk;

  debug_host_seq #(.TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pw_en(i_pw_en), .i_pw_addr(i_pw_addr), .i_pw_data(i_pw_data),
    .i_start(i_start), .i_mode(i_mode), .i_prog_sz(i_prog_sz), .i_steps(i_steps),
    .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
    .i_rx_empty(i_rx_empty), .i_r_data(i_r_data), .o_rd_uart(o_rd_uart),
    .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .o_rx_cnt(o_rx_cnt),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_state(o_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bench-side program copy and per-run observation records
  logic [31:0] prog [DEPTH];
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_tx[$];
  int          tx_cyc[$];
  int          tx_rx_seen[$];

  int   n, rx_seen, rxv_seen, rx_limit, stall_after, stall_left, last_rd_cyc;
  int   wr_when_full, rd_when_empty;
  bit   tx_rand, rx_rand, corrupt_writes, do_start, rx_need_new;
  logic [7:0] cur_rx;

  task automatic cycle();
    @(negedge i_clk);
    i_start = do_start;
    do_start = 1'b0;
    if (stall_left > 0 && got_tx.size() >= stall_after) begin
      i_tx_full = 1'b1;
      stall_left--;
    end else begin
      i_tx_full = tx_rand && ($urandom_range(0, 3) == 0);
    end
    if (rx_need_new) begin
      cur_rx = 8'($urandom);
      rx_need_new = 1'b0;
    end
    i_r_data   = cur_rx;
    i_rx_empty = (rx_seen >= rx_limit) || (rx_rand && ($urandom_range(0, 2) == 0));
    i_pw_en    = corrupt_writes && o_busy;
    i_pw_addr  = 4'($urandom);
    i_pw_data  = $urandom;
    #1;
    if (o_wr_uart) begin
      got_tx.push_back(o_w_data);
      tx_cyc.push_back(n);
      tx_rx_seen.push_back(rx_seen);
      if (i_tx_full) wr_when_full++;
    end
    if (o_rx_valid) begin
      rxv_seen++;
      check_eq("rx_data", {56'd0, o_rx_data}, {56'd0, cur_rx});
    end
    if (o_rd_uart) begin
      if (i_rx_empty) rd_when_empty++;
      rx_seen++;
      rx_need_new = 1'b1;
      last_rd_cyc = n;
    end
    n++;
  endtask

  task automatic load_prog(input int sz, input bit random_data);
    for (int i = 0; i < sz; i++) begin
      @(negedge i_clk);
      if (random_data) prog[i] = $urandom;
      i_pw_en   = 1'b1;
      i_pw_addr = 4'(i);
      i_pw_data = prog[i];
    end
    @(negedge i_clk);
    i_pw_en = 1'b0;
  endtask

  task automatic run(input bit mode, input int sz, input int steps, input int rxl, input int stall);
    bit bad, tmo;
    int cmds, done_cmds, sent_cmds, base, exp_cnt;
    bad       = (sz == 0) || (sz > DEPTH) || (mode && steps == 0);
    cmds      = mode ? steps : 1;
    done_cmds = (rxl / DUMP < cmds) ? rxl / DUMP : cmds;
    tmo       = !bad && (rxl < cmds * DUMP);
    sent_cmds = tmo ? done_cmds + 1 : cmds;
    exp_cnt   = (rxl < cmds * DUMP) ? rxl : cmds * DUMP;
    base      = 2 + sz * NB;

    exp_tx.delete(); got_tx.delete(); tx_cyc.delete(); tx_rx_seen.delete();
    if (!bad) begin
      exp_tx.push_back(8'hFE);
      exp_tx.push_back(8'(sz));
      for (int i = 0; i < sz; i++)
        for (int b = 0; b < NB; b++)
          exp_tx.push_back(8'(prog[i] >> (8 * b)));
      for (int c = 0; c < sent_cmds; c++)
        exp_tx.push_back(mode ? 8'hF1 : 8'hF0);
    end

    n = 0; rx_seen = 0; rxv_seen = 0; rx_limit = rxl;
    wr_when_full = 0; rd_when_empty = 0; last_rd_cyc = 0;
    stall_after = 4; stall_left = stall;
    i_mode = mode; i_prog_sz = 8'(sz); i_steps = 8'(steps);
    do_start = 1'b1;

    forever begin
      cycle();
      if (n >= 2 && !o_busy) break;
      if (n > 20000) begin
        check_eq("run_bound", 64'(n), 64'd20000);
        break;
      end
    end

    if (bad) check_eq("err_next_cycle", 64'(n), 64'd2);
    check_eq("state_done", {61'd0, o_state}, 64'd6);
    check_eq("err", {63'd0, o_err}, {63'd0, bad || tmo});
    check_eq("done", {63'd0, o_done}, {63'd0, !(bad || tmo)});
    if (!bad) check_eq("rx_cnt", {48'd0, o_rx_cnt}, 64'(exp_cnt));
    check_eq("tx_len", 64'(got_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      check_eq($sformatf("tx_byte%0d", i), {56'd0, got_tx[i]}, {56'd0, exp_tx[i]});
    check_eq("rd_pulses", 64'(rx_seen), 64'(bad ? 0 : exp_cnt));
    check_eq("rxv_pulses", 64'(rxv_seen), 64'(bad ? 0 : exp_cnt));
    check_eq("wr_when_full", 64'(wr_when_full), 64'd0);
    check_eq("rd_when_empty", 64'(rd_when_empty), 64'd0);
    for (int k = base; k < got_tx.size(); k++)
      check_eq($sformatf("cmd_after_dump%0d", k - base), 64'(tx_rx_seen[k]), 64'(DUMP * (k - base)));
    if (!bad && !tx_rand && stall == 0 && got_tx.size() > base) begin
      check_eq("first_wr_cyc", 64'(tx_cyc[0]), 64'd1);
      check_eq("cmd_wr_cyc", 64'(tx_cyc[base]), 64'(base + 1));
    end
    if (!bad && stall > 0 && got_tx.size() > 4)
      check_eq("stall_wr_cyc", 64'(tx_cyc[4]), 64'(5 + stall));
    if (tmo) check_eq("idle_cycles", 64'(n - 1 - last_rd_cyc - 1), 64'(TMO));

    cycle();
    check_eq("state_idle", {61'd0, o_state}, 64'd0);
    check_eq("hold_flags", {62'd0, o_done, o_err}, {62'd0, !(bad || tmo), bad || tmo});
  endtask

  function automatic logic [63:0] all_outs();
    return {23'd0, o_wr_uart, o_w_data, o_rd_uart, o_rx_valid, o_rx_data, o_rx_cnt,
            o_busy, o_done, o_err, o_state};
  endfunction

  initial begin
    i_reset = 1'b0; i_pw_en = 1'b0; i_pw_addr = '0; i_pw_data = '0;
    i_start = 1'b0; i_mode = 1'b0; i_prog_sz = '0; i_steps = '0;
    i_tx_full = 1'b0; i_rx_empty = 1'b1; i_r_data = '0;
    tx_rand = 0; rx_rand = 0; corrupt_writes = 0; do_start = 0;
    rx_need_new = 1; cur_rx = '0; rx_limit = 0; rx_seen = 0; stall_left = 0; n = 0;
    repeat (3) @(negedge i_clk);
    #1 check_eq("reset_outputs", all_outs(), 64'd0);
    @(negedge i_clk);
    i_reset = 1'b1;

    prog[0] = 32'h20020002;
    prog[1] = 32'h0000003F;
    load_prog(2, 1'b0);

    run(1'b0, 2, 0, DUMP, 0);          // directed RUN stream
    run(1'b0, 2, 0, DUMP, 5);          // TX stall after the 4th byte
    run(1'b1, 2, 3, 3 * DUMP, 0);      // STEP x3
    run(1'b0, 0, 0, DUMP, 0);          // bad size 0
    run(1'b0, 17, 0, DUMP, 0);         // bad size above depth
    run(1'b1, 2, 0, DUMP, 0);          // STEP with zero steps
    run(1'b0, 2, 0, 10, 0);            // dump timeout

    // Reset in the middle of the instruction bytes, then a clean rerun
    n = 0; rx_seen = 0; rx_limit = 0; stall_left = 0;
    exp_tx.delete(); got_tx.delete(); tx_cyc.delete(); tx_rx_seen.delete();
    i_mode = 1'b0; i_prog_sz = 8'd2; i_steps = 8'd0; do_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (o_state == 3'd3) break;
    end
    check_eq("reached_inst", {61'd0, o_state}, 64'd3);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1 check_eq("mid_reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge i_clk);
    #1 check_eq("held_reset_outputs", all_outs(), 64'd0);
    i_reset = 1'b1;
    run(1'b0, 2, 0, DUMP, 0);

    // Full-depth boundary, then randomized runs with backpressure and writes while busy
    load_prog(DEPTH, 1'b1);
    run(1'b0, DEPTH, 0, DUMP, 0);
    tx_rand = 1; rx_rand = 1; corrupt_writes = 1;
    for (int r = 0; r < 6; r++) begin
      int sz, md, st;
      sz = $urandom_range(1, DEPTH);
      md = $urandom_range(0, 1);
      st = $urandom_range(1, 3);
      corrupt_writes = 0;
      load_prog(sz, 1'b1);
      corrupt_writes = 1;
      run(md[0], sz, st, (md[0] ? st : 1) * DUMP, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_host_seq.md
Name: debug_host_seq

Overview:
- Synthesizable host-side sequencer that drives the debugger command protocol over a UART FIFO interface, so no PC or testbench task is needed.
- Holds a loadable program buffer and streams the load sequence: LOAD_PROG_SIZE, size, then instruction bytes LSB-first.
- Issues RUN, or STEP repeated N times, and collects the register/memory dump bytes returned after each command.
- Sits beside the uart block, on the opposite side from debbugger_top. Used for on-board self-test and in pipeline regression benches.

Parameters:
- INST_SZ, 32, instruction width in bits; must be a multiple of 8.
- PROG_DEPTH, 16, program buffer depth in instructions; must be ≤ 255.
- ADDR_W, 4, program buffer address width; must satisfy 2^ADDR_W ≥ PROG_DEPTH.
- DUMP_BYTES, 66, bytes expected back after each RUN or STEP.
- TIMEOUT, 1000000, idle cycles allowed between received dump bytes before error.
- CMD_LOAD, 8'hFE, LOAD_PROG_SIZE opcode.
- CMD_RUN, 8'hF0, RUN opcode.
- CMD_STEP, 8'hF1, STEP opcode.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_pw_en  in  1  program buffer write enable; ignored while o_busy
- i_pw_addr  in  ADDR_W  program buffer write address
- i_pw_data  in  INST_SZ  program buffer write data
- i_start  in  1  start pulse; ignored while o_busy
- i_mode  in  1  0 = RUN, 1 = STEP; sampled at start
- i_prog_sz  in  8  instruction count to load; sampled at start
- i_steps  in  8  STEP command count; sampled at start
- i_tx_full  in  1  UART TX FIFO full
- o_wr_uart  out  1  TX FIFO write strobe
- o_w_data  out  8  TX byte
- i_rx_empty  in  1  UART RX FIFO empty
- i_r_data  in  8  RX FIFO head byte (first-word-fall-through)
- o_rd_uart  out  1  RX FIFO read/pop strobe
- o_rx_valid  out  1  captured-byte strobe, 1 cycle
- o_rx_data  out  8  captured dump byte
- o_rx_cnt  out  16  total dump bytes captured this run
- o_busy  out  1  sequence in progress
- o_done  out  1  sequence completed; level signal, cleared by next accepted start
- o_err  out  1  bad size or timeout; level signal, cleared by next accepted start
- o_state  out  3  current FSM state encoding

Behaviour:
- Reset (i_reset = 0, asynchronous): state = IDLE and all outputs = 0. Program buffer contents are not reset.
- States: IDLE=0, S_LOAD=1, S_SIZE=2, S_INST=3, S_CMD=4, COLLECT=5, DONE=6.
- IDLE, i_start = 1:
  - If i_prog_sz = 0 or i_prog_sz > PROG_DEPTH, or i_mode = 1 with i_steps = 0: go to DONE with o_err = 1 next cycle; no TX writes.
  - Otherwise: latch inputs, clear o_done, o_err and o_rx_cnt, set o_busy, go to S_LOAD.
- TX rule: in any sending state, o_wr_uart = 1 for exactly the cycles where i_tx_full = 0; o_w_data is valid in the same cycle. A state advances only on a cycle with a write. Back-to-back writes run at 1 byte per cycle. The first write can occur in the cycle after the start is accepted.
- S_LOAD: send CMD_LOAD, then go to S_SIZE.
- S_SIZE: send i_prog_sz[7:0], then go to S_INST.
- S_INST: for each instruction address 0 to prog_sz−1, send INST_SZ/8 bytes, byte 0 = bits [7:0] first. Counters wrap per instruction. After the last byte of the last instruction, go to S_CMD.
- S_CMD: send CMD_RUN (mode 0) or CMD_STEP (mode 1), then go to COLLECT with a per-command byte counter of 0.
- COLLECT:
  - When i_rx_empty = 0: o_rd_uart = 1 and o_rx_valid = 1 in the same cycle, o_rx_data = i_r_data, o_rx_cnt increments. Read rate is up to 1 byte per cycle.
  - The timeout counter resets on each captured byte. If it reaches TIMEOUT: o_err = 1, go to DONE.
  - After DUMP_BYTES bytes: in mode 0, go to DONE. In mode 1, decrement the step count; if the count is not 0, go to S_CMD, else go to DONE.
- Outside COLLECT: o_rd_uart is never asserted, and RX bytes stay in the FIFO.
- DONE: o_busy = 0. o_done = 1 on success only (o_err = 0). Return to IDLE the next cycle; the o_done and o_err levels hold there.
- o_rx_cnt saturates at 16'hFFFF.
- Reset mid-sequence aborts immediately; no partial byte is flagged.

Test Plan:
- Write addr0 = 32'h20020002 (ADDI) and addr1 = 32'h0000003F (HALT); start with prog_sz = 2, mode 0 → TX stream FE,02,02,00,02,20,3F,00,00,00,F0 on consecutive cycles. Then feed 66 RX bytes → 66 o_rx_valid pulses, o_rx_cnt = 66, o_done = 1, o_err = 0.
- Same program, hold i_tx_full = 1 for 5 cycles after the 4th byte → no writes during the stall, no byte lost or duplicated, and the byte order matches the previous scenario.
- Mode 1 with i_steps = 3 → after the instruction bytes, F1 is sent 3 times, each only after 66 RX bytes. Final o_rx_cnt = 198 and o_done = 1.
- i_prog_sz = 0, and separately i_prog_sz = 17 with PROG_DEPTH = 16 → o_err = 1 in the cycle after start, zero o_wr_uart pulses.
- Run with TIMEOUT = 100, supply only 10 RX bytes → o_err = 1 after 100 idle cycles, o_done = 0, o_rx_cnt = 10.
- Assert i_reset low during S_INST, then release and start again → all outputs 0 during reset, and the second run produces the full correct stream starting from FE.
